// File: rtl/fetch_queue_stage.sv
// Fetch stage with a single-outstanding request/valid port to instruction memory
// and a small instruction queue toward decode. Handles redirects and stale responses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_BOOT  | first cycle out of reset, no request issued
// S_IDLE  | no request outstanding, may issue
// S_WAIT  | one request outstanding, its response will be queued
// S_STALE | one request outstanding, its response will be discarded
module fetch_queue_stage #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           BranchTakenE,
    input  logic [XLEN-1:0]                BranchTargetE,
    output logic                           imem_req,
    output logic [XLEN-1:0]                imem_addr,
    input  logic                           imem_ready,
    input  logic                           imem_rvalid,
    input  logic [31:0]                    imem_rdata,
    output logic                           InstrValidD,
    output logic [31:0]                    InstrD,
    output logic [XLEN-1:0]                PCD,
    output logic [XLEN-1:0]                PCPlus4D,
    input  logic                           DecodeReady,
    output logic [$clog2(QUEUE_DEPTH):0]   QueueCount
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_STALE = 2'd3
    } fetch_state_t;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]   count, count_nxt;

    logic [31:0]     q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc4   [QUEUE_DEPTH];

    logic head_valid;
    logic not_full;
    logic accept;
    logic push;
    logic pop;

    assign head_valid = (count != '0);
    assign not_full   = (count < CW'(QUEUE_DEPTH));

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        imem_req     = 1'b0;
        accept       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        imem_req = (state == S_IDLE) && not_full && !BranchTakenE;
        accept   = imem_req && imem_ready;

        case (state)
            S_BOOT:  state_nxt = S_IDLE;
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_IDLE;
                    push      = !BranchTakenE;
                end else if (BranchTakenE) begin
                    state_nxt = S_STALE;
                end
            end
            S_STALE: if (imem_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (BranchTakenE) begin
            // Redirect drops any push/pop this cycle and empties the queue.
            fetch_pc_nxt = BranchTargetE & ~XLEN'(3);
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
        end else begin
            pop = head_valid && DecodeReady;
            if (accept) begin
                fetch_pc_nxt = fetch_pc + XLEN'(4);
                req_pc_nxt   = fetch_pc;
            end
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
        end
    end

    // Payload storage needs no reset; visibility is governed by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc;
            q_pc4[wr_ptr]   <= req_pc + XLEN'(4);
        end
    end

    assign imem_addr   = fetch_pc;
    assign InstrValidD = head_valid;
    assign InstrD      = head_valid ? q_instr[rd_ptr] : '0;
    assign PCD         = head_valid ? q_pc[rd_ptr]    : '0;
    assign PCPlus4D    = head_valid ? q_pc4[rd_ptr]   : '0;
    assign QueueCount  = count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: per-cycle vector table plus a
// hand-written PC wrap sequence on a second instance.
module tb_fetch_queue_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        BranchTakenE = 1'b0;
    logic [31:0] BranchTargetE = '0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        DecodeReady = 1'b0;

    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic        InstrValidD, w_valid;
    logic [31:0] InstrD, w_instr;
    logic [31:0] PCD, w_pc;
    logic [31:0] PCPlus4D, w_pc4;
    logic [2:0]  QueueCount, w_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fetch_queue_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrValidD(InstrValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .DecodeReady(DecodeReady), .QueueCount(QueueCount)
    );

    fetch_queue_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(4)) dut_w (
        .CLK(CLK), .RST(RST), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrValidD(w_valid), .InstrD(w_instr), .PCD(w_pc), .PCPlus4D(w_pc4),
        .DecodeReady(DecodeReady), .QueueCount(w_cnt)
    );

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        dr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic br, input logic [31:0] tgt,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic dr, input logic e_req, input logic [31:0] e_addr,
                                input logic e_v, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic [31:0] e_pc4,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rd = rd; v.dr = dr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] rd, input logic dr);
        @(negedge CLK);
        RST = rst; BranchTakenE = br; BranchTargetE = tgt;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd; DecodeReady = dr;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst br tgt           rdy rv rdata         dr  req addr          v  instr         pc            pc4           cnt
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 1, 32'hA000_0000,1,  0, 32'h4,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h4,        1, 32'hA000_0000,32'h0,        32'h4,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0001,1,  0, 32'h8,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h8,        1, 32'hA000_0001,32'h4,        32'h8,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0002,0,  0, 32'hC,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'hC,        1, 32'hA000_0002,32'h8,        32'hC,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'hC,        1, 32'hA000_0002,32'h8,        32'hC,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'hC,        1, 32'hA000_0002,32'h8,        32'hC,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'hC,        1, 32'hA000_0002,32'h8,        32'hC,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0003,0,  0, 32'h10,       1, 32'hA000_0002,32'h8,        32'hC,        3'd1));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h10,       1, 32'hA000_0002,32'h8,        32'hC,        3'd2));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0004,0,  0, 32'h14,       1, 32'hA000_0002,32'h8,        32'hC,        3'd2));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h14,       1, 32'hA000_0002,32'h8,        32'hC,        3'd3));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0005,0,  0, 32'h18,       1, 32'hA000_0002,32'h8,        32'hC,        3'd3));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h18,       1, 32'hA000_0002,32'h8,        32'hC,        3'd4));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  0, 32'h18,       1, 32'hA000_0002,32'h8,        32'hC,        3'd4));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h18,       1, 32'hA000_0003,32'hC,        32'h10,       3'd3));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h18,       1, 32'hA000_0003,32'hC,        32'h10,       3'd3));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h18,       1, 32'hA000_0004,32'h10,       32'h14,       3'd2));
        vq.push_back(mk(1, 1, 32'h103,      0, 0, 32'h0,        1,  0, 32'h1C,       1, 32'hA000_0004,32'h10,       32'h14,       3'd2));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h100,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 1, 32'hDEAD_0008,1,  0, 32'h100,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h100,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hB000_0000,0,  0, 32'h104,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h104,      1, 32'hB000_0000,32'h100,      32'h104,      3'd1));
        vq.push_back(mk(1, 1, 32'h200,      0, 1, 32'hB000_0001,1,  0, 32'h108,      1, 32'hB000_0000,32'h100,      32'h104,      3'd1));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h200,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hC000_0000,1,  0, 32'h204,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h204,      1, 32'hC000_0000,32'h200,      32'h204,      3'd1));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h204,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 1, 32'h300,      0, 0, 32'h0,        0,  0, 32'h208,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 1, 32'h404,      0, 0, 32'h0,        0,  0, 32'h300,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 1, 32'hBAD0_0204,0,  0, 32'h404,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h404,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hD000_0000,0,  0, 32'h408,      0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h408,      1, 32'hD000_0000,32'h404,      32'h408,      3'd1));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hEEEE_EEEE,0,  0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0,        32'h0,        3'd0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].br, vq[i].tgt, vq[i].rdy, vq[i].rv, vq[i].rd, vq[i].dr);
            chk("imem_req",    i, 32'(imem_req),    32'(vq[i].e_req));
            chk("imem_addr",   i, imem_addr,        vq[i].e_addr);
            chk("InstrValidD", i, 32'(InstrValidD), 32'(vq[i].e_v));
            chk("InstrD",      i, InstrD,           vq[i].e_instr);
            chk("PCD",         i, PCD,              vq[i].e_pc);
            chk("PCPlus4D",    i, PCPlus4D,         vq[i].e_pc4);
            chk("QueueCount",  i, 32'(QueueCount),  32'(vq[i].e_cnt));
        end

        // PC wrap on the instance reset to 0xFFFF_FFFC.
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("wrap_reset_addr", 0, w_addr, 32'hFFFF_FFFC);
        chk("wrap_reset_req",  0, 32'(w_req), 32'h0);
        chk("wrap_reset_cnt",  0, 32'(w_cnt), 32'h0);
        drive(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("wrap_boot_req",   1, 32'(w_req), 32'h0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 5 && !seen; k++) begin
                drive(1, 0, 32'h0, 1, 0, 32'h0, 0);
                seen = w_req;
            end
            chk("wrap_req_seen", 2, 32'(seen), 32'h1);
        end
        chk("wrap_first_addr", 2, w_addr, 32'hFFFF_FFFC);
        drive(1, 0, 32'h0, 0, 1, 32'h1234_5678, 0);
        chk("wrap_second_addr", 3, w_addr, 32'h0000_0000);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("wrap_valid",  4, 32'(w_valid), 32'h1);
        chk("wrap_instr",  4, w_instr, 32'h1234_5678);
        chk("wrap_pc",     4, w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",    4, w_pc4, 32'h0000_0000);
        chk("wrap_req",    4, 32'(w_req), 32'h1);
        chk("wrap_cnt",    4, 32'(w_cnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
